// File: rtl/mrr_corr_sequencer_pkg.sv
// Shared definitions for the correlation-pass sequencer: state encoding,
// error codes and default widths.
package mrr_corr_sequencer_pkg;

  localparam int REPLAY_LEN_WIDTH_DEF = 16;
  localparam int TIMEOUT_WIDTH_DEF    = 24;
  localparam int STAT_WIDTH_DEF       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REPLAY,
    ST_SEARCH,
    ST_HEADER,
    ST_SYNCD,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE           = 2'd0,
    ERR_SEARCH_TIMEOUT = 2'd1,
    ERR_SYNC_TIMEOUT   = 2'd2,
    ERR_ABORT          = 2'd3
  } err_code_t;

endpackage

// File: rtl/mrr_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module mrr_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mrr_corr_sequencer.sv
// Sequences one correlation pass: replay framing, correlator search and header
// phases under watchdogs, reporting sync success or a coded error.
module mrr_corr_sequencer
  import mrr_corr_sequencer_pkg::*;
#(
  parameter int REPLAY_LEN_WIDTH = REPLAY_LEN_WIDTH_DEF,
  parameter int TIMEOUT_WIDTH    = TIMEOUT_WIDTH_DEF,
  parameter int STAT_WIDTH       = STAT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [REPLAY_LEN_WIDTH-1:0] replay_len,
  input  logic [TIMEOUT_WIDTH-1:0]    search_timeout,
  input  logic [TIMEOUT_WIDTH-1:0]    sync_timeout,
  input  logic                        i_tkeep,
  input  logic                        correlation_done,
  input  logic                        syncd_flag,
  output logic                        o_replay_flag,
  output logic                        o_replay_header_flag,
  output logic                        o_rst_corr_state,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [1:0]                  err_code,
  output logic [STAT_WIDTH-1:0]       stat_passes,
  output logic [STAT_WIDTH-1:0]       stat_syncs,
  output logic [STAT_WIDTH-1:0]       stat_errors
);

  state_t                      state, state_next;
  err_code_t                   err_q, err_val;
  logic                        err_set;
  logic [REPLAY_LEN_WIDTH-1:0] len_q, kept_q, kept_inc;
  logic [TIMEOUT_WIDTH-1:0]    wd;
  logic                        wd_clr, wd_inc;

  assign kept_inc = kept_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      len_q  <= '0;
      kept_q <= '0;
      err_q  <= ERR_NONE;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) len_q <= replay_len;
      if (state != ST_REPLAY)        kept_q <= '0;
      else if (i_tkeep)              kept_q <= kept_inc;
      if (err_set)                   err_q <= err_val;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    err_val    = ERR_NONE;
    // ERR already reports and returns to IDLE, so abort only acts on live phases
    if (abort && (state inside {ST_REPLAY, ST_SEARCH, ST_HEADER, ST_SYNCD})) begin
      state_next = ST_ERR;
      err_set    = 1'b1;
      err_val    = ERR_ABORT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (replay_len == '0) begin
              state_next = ST_ERR;
              err_set    = 1'b1;
              err_val    = ERR_SEARCH_TIMEOUT;
            end else begin
              state_next = ST_REPLAY;
            end
          end
        end
        ST_REPLAY: if (i_tkeep && (kept_inc == len_q)) state_next = ST_SEARCH;
        ST_SEARCH: begin
          // A correlator result beats a watchdog expiry in the same cycle
          if (correlation_done) begin
            state_next = ST_HEADER;
          end else if (wd == search_timeout) begin
            state_next = ST_ERR;
            err_set    = 1'b1;
            err_val    = ERR_SEARCH_TIMEOUT;
          end
        end
        ST_HEADER: begin
          if (syncd_flag) begin
            state_next = ST_SYNCD;
          end else if (wd == sync_timeout) begin
            state_next = ST_ERR;
            err_set    = 1'b1;
            err_val    = ERR_SYNC_TIMEOUT;
          end
        end
        ST_SYNCD: state_next = ST_IDLE;
        ST_ERR:   state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Watchdog restarts from zero on every state change, so entry cycle reads 0
  assign wd_clr = (state_next != state);
  assign wd_inc = (state == ST_SEARCH) || (state == ST_HEADER);

  mrr_sat_counter #(.WIDTH(TIMEOUT_WIDTH)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr),
    .inc   (wd_inc),
    .count (wd)
  );

  mrr_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_passes (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (state == ST_IDLE && start),
    .count (stat_passes)
  );

  mrr_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_syncs (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (state == ST_SYNCD),
    .count (stat_syncs)
  );

  mrr_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_errors (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (state == ST_ERR),
    .count (stat_errors)
  );

  // All outputs decode the state register, so they never glitch on inputs
  assign o_replay_flag        = (state == ST_REPLAY);
  assign o_replay_header_flag = (state == ST_HEADER);
  assign o_rst_corr_state     = (state == ST_ERR);
  assign error                = (state == ST_ERR);
  assign done                 = (state == ST_SYNCD);
  assign busy                 = (state != ST_IDLE);
  assign err_code             = err_q;

endmodule

// File: tb/tb_mrr_corr_sequencer.sv
// Scoreboard bench for mrr_corr_sequencer: stimulus queues expected events,
// a negedge monitor compares flag windows and done/error pulses in order.
module tb_mrr_corr_sequencer;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic        start, abort, i_tkeep, correlation_done, syncd_flag;
  logic [15:0] replay_len;
  logic [23:0] search_timeout, sync_timeout;

  logic        o_replay_flag, o_replay_header_flag, o_rst_corr_state;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] stat_passes, stat_syncs, stat_errors;

  logic        rf_b, hf_b, rc_b, busy_b, done_b, error_b;
  logic [1:0]  ec_b;
  logic [1:0]  sp_b, ss_b, se_b;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int exp_passes = 0, exp_syncs = 0, exp_errors = 0;
  int tot_passes = 0, tot_syncs = 0, tot_errors = 0;

  typedef enum logic [1:0] {EV_REPLAY_END, EV_HEADER_END, EV_DONE, EV_ERROR} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       val;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mrr_corr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .replay_len(replay_len),
    .search_timeout(search_timeout), .sync_timeout(sync_timeout), .i_tkeep(i_tkeep),
    .correlation_done(correlation_done), .syncd_flag(syncd_flag),
    .o_replay_flag(o_replay_flag), .o_replay_header_flag(o_replay_header_flag),
    .o_rst_corr_state(o_rst_corr_state), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .stat_passes(stat_passes), .stat_syncs(stat_syncs),
    .stat_errors(stat_errors)
  );

  // Narrow-statistics twin sharing the stimulus, used to reach saturation quickly
  mrr_corr_sequencer #(.STAT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(start), .abort(abort), .replay_len(replay_len),
    .search_timeout(search_timeout), .sync_timeout(sync_timeout), .i_tkeep(i_tkeep),
    .correlation_done(correlation_done), .syncd_flag(syncd_flag),
    .o_replay_flag(rf_b), .o_replay_header_flag(hf_b), .o_rst_corr_state(rc_b),
    .busy(busy_b), .done(done_b), .error(error_b), .err_code(ec_b),
    .stat_passes(sp_b), .stat_syncs(ss_b), .stat_errors(se_b)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got %s at cycle %0d expected none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check("event_cycle", cyc, e.cyc);
      check("event_value", v, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_passes"}, int'(stat_passes), exp_passes);
    check({tag, "_syncs"},  int'(stat_syncs),  exp_syncs);
    check({tag, "_errors"}, int'(stat_errors), exp_errors);
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  // Starts a one-sample pass and returns at the first SEARCH cycle
  task automatic short_replay(output int s);
    int c0;
    c0 = cyc;
    start = 1'b1;
    replay_len = 16'd1;
    exp_passes++;
    tot_passes++;
    expect_ev(EV_REPLAY_END, c0 + 2, 1);
    tick(1);
    start   = 1'b0;
    i_tkeep = 1'b1;
    tick(1);
    i_tkeep = 1'b0;
    s = cyc;
  endtask

  // Monitor: turns flag windows and pulses into events and pops the scoreboard
  initial begin
    int   rep_rise, hdr_rise;
    logic rep_prev, hdr_prev;
    rep_rise = 0;
    hdr_rise = 0;
    rep_prev = 1'b0;
    hdr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_replay_flag === 1'b1 && !rep_prev) rep_rise = cyc;
      if (o_replay_flag === 1'b0 && rep_prev) observe(EV_REPLAY_END, cyc - rep_rise);
      if (o_replay_header_flag === 1'b1 && !hdr_prev) hdr_rise = cyc;
      if (o_replay_header_flag === 1'b0 && hdr_prev) observe(EV_HEADER_END, cyc - hdr_rise);
      if (done === 1'b1) observe(EV_DONE, 0);
      if (error === 1'b1) observe(EV_ERROR, int'(err_code));
      if (error === 1'b1 || o_rst_corr_state === 1'b1)
        check("rst_corr_with_error", int'(o_rst_corr_state), int'(error));
      rep_prev = (o_replay_flag === 1'b1);
      hdr_prev = (o_replay_header_flag === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100000ns");
    $fatal(1, "bench timed out");
  end

  initial begin
    int c0, s, h;
    rst = 1'b1; rst_b = 1'b1;
    start = 1'b0; abort = 1'b0; i_tkeep = 1'b0;
    correlation_done = 1'b0; syncd_flag = 1'b0;
    replay_len = '0; search_timeout = 24'd1000; sync_timeout = 24'd1000;
    tick(3);
    rst = 1'b0; rst_b = 1'b0;

    check("reset_busy", int'(busy), 0);
    check("reset_replay_flag", int'(o_replay_flag), 0);
    check("reset_header_flag", int'(o_replay_header_flag), 0);
    check("reset_err_code", int'(err_code), 0);
    check_stats("reset");

    // 1. Nominal: 8 kept samples every 2nd cycle, header, sync
    c0 = cyc;
    start = 1'b1; replay_len = 16'd8;
    exp_passes++; tot_passes++;
    expect_ev(EV_REPLAY_END, c0 + 17, 16);
    tick(1);
    start = 1'b0;
    check("nominal_busy", int'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      i_tkeep = (k % 2 == 0);
      tick(1);
    end
    i_tkeep = 1'b0;
    s = cyc;
    tick(20);
    correlation_done = 1'b1;
    tick(1);
    correlation_done = 1'b0;
    h = cyc;
    check("nominal_header_flag", int'(o_replay_header_flag), 1);
    tick(5);
    syncd_flag = 1'b1;
    expect_ev(EV_HEADER_END, h + 6, 6);
    expect_ev(EV_DONE, h + 6, 0);
    exp_syncs++; tot_syncs++;
    tick(1);
    syncd_flag = 1'b0;
    tick(2);
    check_stats("nominal");

    // 2. Search timeout at watchdog 50
    search_timeout = 24'd50;
    short_replay(s);
    expect_ev(EV_ERROR, s + 51, 1);
    exp_errors++; tot_errors++;
    tick(53);
    check("search_to_err_code_held", int'(err_code), 1);
    check_stats("search_to");

    // 3. Sync timeout at watchdog 100
    search_timeout = 24'd1000; sync_timeout = 24'd100;
    short_replay(s);
    tick(3);
    correlation_done = 1'b1;
    tick(1);
    correlation_done = 1'b0;
    h = cyc;
    expect_ev(EV_HEADER_END, h + 101, 101);
    expect_ev(EV_ERROR, h + 101, 2);
    exp_errors++; tot_errors++;
    tick(104);
    check_stats("sync_to");

    // 4. Abort after 3 kept samples; abort in IDLE is ignored
    sync_timeout = 24'd1000;
    c0 = cyc;
    start = 1'b1; replay_len = 16'd8;
    exp_passes++; tot_passes++;
    expect_ev(EV_REPLAY_END, c0 + 5, 4);
    expect_ev(EV_ERROR, c0 + 5, 3);
    exp_errors++; tot_errors++;
    tick(1);
    start = 1'b0; i_tkeep = 1'b1;
    tick(3);
    i_tkeep = 1'b0; abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);
    check_stats("abort");
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    check("idle_abort_busy", int'(busy), 0);

    // 5. Tie: correlation_done on watchdog 50; start while busy ignored
    search_timeout = 24'd50;
    short_replay(s);
    tick(50);
    correlation_done = 1'b1;
    tick(1);
    correlation_done = 1'b0;
    h = cyc;
    check("tie_done_header_flag", int'(o_replay_header_flag), 1);
    tick(2);
    start = 1'b1; replay_len = 16'd4;
    tick(1);
    start = 1'b0;
    tick(1);
    syncd_flag = 1'b1;
    expect_ev(EV_HEADER_END, h + 5, 5);
    expect_ev(EV_DONE, h + 5, 0);
    exp_syncs++; tot_syncs++;
    tick(1);
    syncd_flag = 1'b0;
    tick(2);
    check_stats("tie_done");

    // 5b. Tie: syncd_flag on watchdog == sync_timeout
    search_timeout = 24'd1000; sync_timeout = 24'd3;
    short_replay(s);
    correlation_done = 1'b1;
    tick(1);
    correlation_done = 1'b0;
    h = cyc;
    tick(3);
    syncd_flag = 1'b1;
    expect_ev(EV_HEADER_END, h + 4, 4);
    expect_ev(EV_DONE, h + 4, 0);
    exp_syncs++; tot_syncs++;
    tick(1);
    syncd_flag = 1'b0;
    tick(2);
    check_stats("tie_sync");

    // 6a. Zero replay length, and zero search timeout
    sync_timeout = 24'd1000;
    c0 = cyc;
    start = 1'b1; replay_len = 16'd0;
    exp_passes++; tot_passes++;
    expect_ev(EV_ERROR, c0 + 1, 1);
    exp_errors++; tot_errors++;
    tick(1);
    start = 1'b0;
    tick(2);
    search_timeout = 24'd0;
    short_replay(s);
    expect_ev(EV_ERROR, s + 1, 1);
    exp_errors++; tot_errors++;
    tick(3);
    check_stats("zero_cases");

    // 6b. Reset while in HEADER
    search_timeout = 24'd1000;
    short_replay(s);
    correlation_done = 1'b1;
    tick(1);
    correlation_done = 1'b0;
    h = cyc;
    tick(2);
    rst = 1'b1;
    expect_ev(EV_HEADER_END, h + 3, 3);
    tick(1);
    check("rst_header_flag", int'(o_replay_header_flag), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err_code", int'(err_code), 0);
    exp_passes = 0; exp_syncs = 0; exp_errors = 0;
    check_stats("rst_mid");
    rst = 1'b0;
    tick(1);

    // 6c. Drive the narrow twin well past all-ones
    for (int i = 0; i < 4; i++) begin
      c0 = cyc;
      start = 1'b1; replay_len = 16'd0;
      exp_passes++; tot_passes++;
      expect_ev(EV_ERROR, c0 + 1, 1);
      exp_errors++; tot_errors++;
      tick(1);
      start = 1'b0;
      tick(2);
    end
    check_stats("post_rst");
    check("sat_passes", int'(sp_b), sat3(tot_passes));
    check("sat_syncs",  int'(ss_b), sat3(tot_syncs));
    check("sat_errors", int'(se_b), sat3(tot_errors));

    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
